// File: rtl/mac_pkg.sv
// Shared types and sizing for the shift-and-add MAC sequencer.
package mac_pkg;
  localparam int OPW        = 8;
  localparam int PRODW      = 16;
  localparam int MUL_CYCLES = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } state_t;
endpackage

// File: rtl/mac_add8.sv
// 8-bit unsigned adder producing an 8-bit sum and a carry-out.
module mac_add8
  import mac_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [OPW-1:0] sum,
  output logic           carry
);
  assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/mac_sequencer.sv
// Multi-cycle multiply-accumulate sequencer: shift-and-add multiply, then
// accumulate, presenting the running sum after an element flagged last.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int ACC_WIDTH = 20,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPW-1:0]       A,
  input  logic [OPW-1:0]       B,
  input  logic                 in_last,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic [CNT_WIDTH-1:0] elem_count,
  output logic                 overflow,
  output logic                 busy
);
  localparam int BCW = $clog2(MUL_CYCLES);

  state_t               state;
  state_t               state_nxt;
  logic [OPW-1:0]       a_q;
  logic [OPW-1:0]       hi;
  logic [OPW-1:0]       lo;
  logic [BCW-1:0]       bitcnt;
  logic                 last_q;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf;
  logic [OPW-1:0]       addend;
  logic [OPW-1:0]       sum;
  logic                 carry;
  logic [ACC_WIDTH:0]   acc_sum;
  logic                 mul_done;
  logic                 drain;

  // Element counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Partial-product step: add the multiplicand only when the current multiplier bit is set.
  assign addend = lo[0] ? a_q : '0;

  mac_add8 u_add (
    .a     (hi),
    .b     (addend),
    .sum   (sum),
    .carry (carry)
  );

  // One extra bit catches the accumulator wrap for the sticky overflow flag.
  assign acc_sum  = {1'b0, acc} + {{(ACC_WIDTH + 1 - PRODW){1'b0}}, hi, lo};
  assign mul_done = (bitcnt == BCW'(MUL_CYCLES - 1));
  assign drain    = (state == OUT) && out_ready;

  assign in_ready   = (state == IDLE) && !rst;
  assign out_valid  = (state == OUT);
  assign busy       = (state != IDLE);
  assign result     = acc;
  assign elem_count = cnt;
  assign overflow   = ovf;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = MUL;
      MUL:     if (mul_done)  state_nxt = ACC;
      ACC:     state_nxt = last_q ? OUT : IDLE;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and shift-and-add product register {hi,lo}.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      hi     <= '0;
      lo     <= '0;
      bitcnt <= '0;
      last_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_q    <= A;
      hi     <= '0;
      lo     <= B;
      bitcnt <= '0;
      last_q <= in_last;
    end else if (state == MUL) begin
      hi     <= {carry, sum[OPW-1:1]};
      lo     <= {sum[0], lo[OPW-1:1]};
      bitcnt <= bitcnt + BCW'(1);
    end
  end

  // Accumulator, element count and sticky overflow; zeroed by clear in IDLE or by a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if ((state == IDLE && clear) || drain) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == ACC) begin
      acc <= acc_sum[ACC_WIDTH-1:0];
      ovf <= ovf | acc_sum[ACC_WIDTH];
      cnt <= sat_inc(cnt);
    end
  end
endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: two instances (20-bit and 16-bit
// accumulators), directed corner cases plus randomized operand streams.
module tb_mac_sequencer;
  typedef struct {
    longint res;
    int     cnt;
    bit     ovf;
    int     acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  logic       in_valid  [2];
  logic       in_ready  [2];
  logic       in_last   [2];
  logic       clear     [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic       overflow  [2];
  logic       busy      [2];
  logic [7:0] a_in      [2];
  logic [7:0] b_in      [2];
  logic [7:0] cnt       [2];
  logic [19:0] result0;
  logic [15:0] result1;

  exp_t   sbq0[$];
  exp_t   sbq1[$];
  longint msum [2];
  int     mcnt [2];
  bit     ready_rand [2];
  logic   ready_fix  [2];
  bit     prev_v [2];
  int     rise_cyc [2];
  int     n_cmp = 0;
  int     n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_sequencer #(.ACC_WIDTH(20), .CNT_WIDTH(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .A(a_in[0]), .B(b_in[0]), .in_last(in_last[0]), .clear(clear[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result0),
    .elem_count(cnt[0]), .overflow(overflow[0]), .busy(busy[0])
  );

  mac_sequencer #(.ACC_WIDTH(16), .CNT_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .A(a_in[1]), .B(b_in[1]), .in_last(in_last[1]), .clear(clear[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result1),
    .elem_count(cnt[1]), .overflow(overflow[1]), .busy(busy[1])
  );

  function automatic longint res_of(input int i);
    return (i == 0) ? longint'(result0) : longint'(result1);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: true sum of products since the last clear/drain.
  task automatic model_accept(input int i, input logic [7:0] a, input logic [7:0] b,
                              input bit last, input bit clr, input bit push, input int k);
    longint lim = longint'(1) << ((i == 0) ? 20 : 16);
    exp_t e;
    if (clr) begin
      msum[i] = 0;
      mcnt[i] = 0;
    end
    msum[i] += longint'(a) * longint'(b);
    mcnt[i] += 1;
    if (last) begin
      e.res     = msum[i] % lim;
      e.cnt     = (mcnt[i] > 255) ? 255 : mcnt[i];
      e.ovf     = (msum[i] >= lim);
      e.acc_cyc = k;
      if (push) begin
        if (i == 0) sbq0.push_back(e);
        else        sbq1.push_back(e);
      end
      msum[i] = 0;
      mcnt[i] = 0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input int i, input logic [7:0] a, input logic [7:0] b, input bit last,
                      input bit clr, input bit push, output int waits, output int k);
    waits = 0;
    k = 0;
    in_valid[i] = 1'b1;
    a_in[i]     = a;
    b_in[i]     = b;
    in_last[i]  = last;
    clear[i]    = clr;
    @(negedge clk);
    while (!in_ready[i] && waits < 3000) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready[i]) begin
      check("send_timeout_in_ready", in_ready[i], 1);
      in_valid[i] = 1'b0;
      clear[i]    = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    k = cyc;
    in_valid[i] = 1'b0;
    in_last[i]  = 1'b0;
    clear[i]    = 1'b0;
    model_accept(i, a, b, last, clr, push, k);
  endtask

  // Returns at the negedge of the first cycle with out_valid high.
  task automatic wait_out(input int i);
    int n = 0;
    @(negedge clk);
    while (!out_valid[i] && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (!out_valid[i]) check("wait_out_timeout", out_valid[i], 1);
  endtask

  // Returns at posedge+1 once the instance is idle and ready.
  task automatic wait_idle(input int i);
    int n = 0;
    @(negedge clk);
    while (!(in_ready[i] && !out_valid[i]) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready[i]) check("wait_idle_timeout", in_ready[i], 1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] v;
    case ($urandom_range(0, 5))
      0:       v = 8'd0;
      1:       v = 8'd255;
      default: v = 8'($urandom_range(0, 255));
    endcase
    return v;
  endfunction

  // out_ready driver: fixed or random, updated just after each rising edge.
  initial begin
    for (int i = 0; i < 2; i++) out_ready[i] = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++)
        out_ready[i] = ready_rand[i] ? 1'($urandom_range(0, 1)) : ready_fix[i];
    end
  end

  // Monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        prev_v[i] = 1'b0;
      end else begin
        if (out_valid[i] && !prev_v[i]) rise_cyc[i] = cyc;
        if (out_valid[i] && out_ready[i]) begin
          exp_t e;
          bit   got;
          got = 1'b0;
          if (i == 0 && sbq0.size() > 0) begin e = sbq0.pop_front(); got = 1'b1; end
          if (i == 1 && sbq1.size() > 0) begin e = sbq1.pop_front(); got = 1'b1; end
          if (!got) begin
            check($sformatf("sb%0d_unexpected_output", i), (i == 0) ? sbq0.size() : sbq1.size(), 1);
          end else begin
            check($sformatf("sb%0d_result", i), res_of(i), e.res);
            check($sformatf("sb%0d_elem_count", i), cnt[i], e.cnt);
            check($sformatf("sb%0d_overflow", i), overflow[i], e.ovf);
            check($sformatf("sb%0d_latency", i), rise_cyc[i] - e.acc_cyc, 9);
          end
        end
        prev_v[i] = out_valid[i];
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, k;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_last[i] = 1'b0; clear[i] = 1'b0;
      a_in[i] = '0; b_in[i] = '0;
      ready_fix[i] = 1'b1; ready_rand[i] = 1'b0;
      msum[i] = 0; mcnt[i] = 0; prev_v[i] = 1'b0; rise_cyc[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("in_ready_during_rst", in_ready[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_result", result0, 0);
    check("rst_elem_count", cnt[0], 0);
    check("rst_overflow", overflow[0], 0);
    check("rst_in_ready", in_ready[0], 1);
    @(posedge clk); #1;

    // 3 x 5, single element
    send(0, 8'd3, 8'd5, 1'b1, 1'b0, 1'b1, w, k);
    wait_out(0);
    check("t1_latency", cyc - k, 9);
    check("t1_result", result0, 15);
    check("t1_elem_count", cnt[0], 1);
    @(negedge clk);
    check("t1_in_ready_after_drain", in_ready[0], 1);
    check("t1_busy_after_drain", busy[0], 0);
    @(posedge clk); #1;

    // largest single product
    send(0, 8'd255, 8'd255, 1'b1, 1'b0, 1'b1, w, k);
    wait_out(0);
    check("t2_result", result0, 65025);
    wait_idle(0);

    // four-element accumulation
    send(0, 8'd2, 8'd3, 1'b0, 1'b0, 1'b1, w, k);
    send(0, 8'd10, 8'd10, 1'b0, 1'b0, 1'b1, w, k);
    check("t3_gap_2", w, 9);
    send(0, 8'd0, 8'd200, 1'b0, 1'b0, 1'b1, w, k);
    check("t3_gap_3", w, 9);
    send(0, 8'd17, 8'd15, 1'b1, 1'b0, 1'b1, w, k);
    check("t3_gap_4", w, 9);
    wait_out(0);
    check("t3_result", result0, 361);
    check("t3_elem_count", cnt[0], 4);
    wait_idle(0);

    // 16-bit accumulator wrap
    send(1, 8'd255, 8'd255, 1'b0, 1'b0, 1'b1, w, k);
    send(1, 8'd255, 8'd255, 1'b1, 1'b0, 1'b1, w, k);
    wait_out(1);
    check("t4_wrap_result", result1, 64514);
    check("t4_wrap_overflow", overflow[1], 1);
    wait_idle(1);
    send(1, 8'd1, 8'd1, 1'b1, 1'b0, 1'b1, w, k);
    wait_out(1);
    check("t4_after_drain_result", result1, 1);
    check("t4_after_drain_overflow", overflow[1], 0);
    wait_idle(1);

    // backpressure while offering input and clear
    ready_fix[0] = 1'b0;
    send(0, 8'd12, 8'd13, 1'b1, 1'b0, 1'b1, w, k);
    wait_out(0);
    @(posedge clk); #1;
    in_valid[0] = 1'b1; clear[0] = 1'b1; a_in[0] = 8'd99; b_in[0] = 8'd99;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_out_valid_held", out_valid[0], 1);
      check("bp_in_ready_low", in_ready[0], 0);
      check("bp_result_held", result0, 156);
      check("bp_count_held", cnt[0], 1);
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0; clear[0] = 1'b0; ready_fix[0] = 1'b1;
    wait_idle(0);
    check("bp_drain_result_zero", result0, 0);
    check("bp_drain_count_zero", cnt[0], 0);

    // reset during the 4th MUL cycle
    send(0, 8'd200, 8'd200, 1'b1, 1'b0, 1'b0, w, k);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin msum[i] = 0; mcnt[i] = 0; end
    @(negedge clk);
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_out_valid", out_valid[0], 0);
    check("mid_rst_result", result0, 0);
    check("mid_rst_in_ready_after", in_ready[0], 1);
    @(posedge clk); #1;
    send(0, 8'd7, 8'd6, 1'b1, 1'b0, 1'b1, w, k);
    wait_out(0);
    check("post_rst_result", result0, 42);
    wait_idle(0);

    // clear together with accept discards the partial sum
    send(0, 8'd9, 8'd9, 1'b0, 1'b0, 1'b1, w, k);
    send(0, 8'd4, 8'd5, 1'b1, 1'b1, 1'b1, w, k);
    wait_out(0);
    check("clear_accept_result", result0, 20);
    check("clear_accept_count", cnt[0], 1);
    wait_idle(0);

    // elem_count saturation
    for (int n = 0; n < 260; n++)
      send(0, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), (n == 259), 1'b0, 1'b1, w, k);
    wait_out(0);
    check("sat_elem_count", cnt[0], 255);
    wait_idle(0);

    // randomized streams with random backpressure
    ready_rand[0] = 1'b1;
    ready_rand[1] = 1'b1;
    for (int n = 0; n < 40; n++)
      send(0, pick(), pick(), ($urandom_range(0, 3) == 0) || (n == 39),
           ($urandom_range(0, 7) == 0), 1'b1, w, k);
    for (int n = 0; n < 30; n++)
      send(1, pick(), pick(), ($urandom_range(0, 3) == 0) || (n == 29),
           ($urandom_range(0, 7) == 0), 1'b1, w, k);
    ready_rand[0] = 1'b0;
    ready_rand[1] = 1'b0;
    wait_idle(0);
    wait_idle(1);
    repeat (3) @(posedge clk);
    check("sb0_drained", sbq0.size(), 0);
    check("sb1_drained", sbq1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
